// File: rtl/ad7980_pkg.sv
// Shared constants, FSM state type and parameter check for ad7980_array.
// No ports; imported by the lane and top modules.
package ad7980_pkg;

  localparam int ADC_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ACQUIRE,
    WAIT
  } state_t;

  function automatic bit period_ok(
    input int per,
    input int cnv,
    input int div
  );
    return (div >= 1) &&
           (per >= cnv + 2 * ADC_BITS * div + 2);
  endfunction

endpackage

// File: rtl/ad7980_rx_lane.sv
// One SDO lane: 16-bit MSB-first shift register with clear and MSB invert.
// Ports: i_clk, i_rst_n, i_clr, i_shift, i_sdo in; o_data[15:0] out.
module ad7980_rx_lane
  import ad7980_pkg::*;
#(
  parameter bit INV_MSB = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_shift,
  input  logic                i_sdo,
  output logic [ADC_BITS-1:0] o_data
);

  logic [ADC_BITS-1:0] r_sh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_clr) begin
      r_sh <= '0;
    end else if (i_shift) begin
      r_sh <= {r_sh[ADC_BITS-2:0], i_sdo};
    end
  end

  assign o_data = {r_sh[ADC_BITS-1] ^ INV_MSB,
                   r_sh[ADC_BITS-2:0]};

endmodule

// File: rtl/ad7980_array.sv
// NUM_CH AD7980 capture engine: shared CNV/SCLK, parallel SDO, AXIS out.
// Ports: aclk, aresetn, cfg_enable, sdo, m_axis_tready in; cnv, sclk, m_axis_tdata, m_axis_tvalid, overrun_count out. Macro AD7980_ARRAY_TWOS_COMP_EN selects two's complement lanes.
module ad7980_array
  import ad7980_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CLK_DIV       = 2,
  parameter int CNV_CYCLES    = 71,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_enable,
  input  logic [NUM_CH-1:0]            sdo,
  output logic                         cnv,
  output logic                         sclk,
  output logic [ADC_BITS*NUM_CH-1:0]   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [15:0]                  overrun_count
);

  if (!period_ok(SAMPLE_PERIOD, CNV_CYCLES, CLK_DIV))
  begin : g_bad_cfg
    $error("ad7980_array: SAMPLE_PERIOD too short");
  end

`ifdef AD7980_ARRAY_TWOS_COMP_EN
  localparam bit LP_INV = 1'b1;
`else
  localparam bit LP_INV = 1'b0;
`endif

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LP_PER_LAST =
    PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] LP_CNV_LAST =
    PW'(CNV_CYCLES - 1);
  localparam logic [DW-1:0] LP_DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [4:0] LP_HALF_LAST = 5'd31;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [PW-1:0]                r_per;
  logic [DW-1:0]                r_div;
  logic [4:0]                   r_half;
  logic                         r_sclk;
  logic                         r_cnv;
  logic                         r_tvalid;
  logic [ADC_BITS*NUM_CH-1:0]   r_tdata;
  logic [15:0]                  r_ovr;
  logic [ADC_BITS*NUM_CH-1:0]   w_frame;
  logic                         w_div_end;
  logic                         w_acq_done;
  logic                         w_shift;
  logic                         w_cnv_end;
  logic                         w_per_end;

  assign w_div_end  = (r_div == LP_DIV_LAST);
  assign w_per_end  = (r_per == LP_PER_LAST);
  assign w_cnv_end  = (r_state == CONVERT) &&
                      (r_per == LP_CNV_LAST);
  // r_half[0] is the sclk level; a low half ending means a rising edge.
  assign w_shift    = (r_state == ACQUIRE) &&
                      w_div_end && !r_half[0];
  assign w_acq_done = (r_state == ACQUIRE) &&
                      w_div_end &&
                      (r_half == LP_HALF_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (cfg_enable) w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (w_cnv_end) w_state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (w_acq_done)
          w_state_nxt = cfg_enable ? WAIT : IDLE;
      end
      WAIT: begin
        if (w_per_end)
          w_state_nxt = cfg_enable ? CONVERT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_per <= '0;
      r_cnv <= 1'b0;
    end else begin
      r_cnv <= (w_state_nxt == CONVERT);
      if (w_state_nxt == IDLE) begin
        r_per <= '0;
      end else if (w_state_nxt == CONVERT &&
                   r_state != CONVERT) begin
        r_per <= '0;
      end else begin
        r_per <= r_per + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_div  <= '0;
      r_half <= '0;
      r_sclk <= 1'b0;
    end else if (r_state == ACQUIRE) begin
      if (w_div_end) begin
        r_div  <= '0;
        r_half <= r_half + 1'b1;
        r_sclk <= ~r_sclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else begin
      r_div  <= '0;
      r_half <= '0;
      r_sclk <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    ad7980_rx_lane #(
      .INV_MSB (LP_INV)
    ) u_lane (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_clr   (w_cnv_end),
      .i_shift (w_shift),
      .i_sdo   (sdo[k]),
      .o_data  (w_frame[k*ADC_BITS +: ADC_BITS])
    );
  end

  // A frame landing on a held, unaccepted beat is dropped and counted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_ovr    <= '0;
    end else if (w_acq_done) begin
      if (!r_tvalid || m_axis_tready) begin
        r_tdata  <= w_frame;
        r_tvalid <= 1'b1;
      end else if (r_ovr != 16'hFFFF) begin
        r_ovr <= r_ovr + 1'b1;
      end
    end else if (r_tvalid && m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign cnv           = r_cnv;
  assign sclk          = r_sclk;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign overrun_count = r_ovr;

endmodule

// File: tb/tb_ad7980_array.sv
// Scoreboard bench for ad7980_array with behavioural AD7980 models.
// Covers reset abort, latency, cadence, back-pressure and stop.
module tb_ad7980_array;

  localparam int NCH = 4;
  localparam int CLK_DIV = 2;
  localparam int CNV_CYCLES = 71;
  localparam int SAMPLE_PERIOD = 200;
  localparam int LAT = CNV_CYCLES + 32 * CLK_DIV;

`ifdef AD7980_ARRAY_TWOS_COMP_EN
  localparam logic [63:0] FMT = 64'h8000_8000_8000_8000;
`else
  localparam logic [63:0] FMT = 64'h0;
`endif

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            cfg_enable = 1'b0;
  logic            m_axis_tready = 1'b1;
  logic [NCH-1:0]  sdo;
  logic            cnv;
  logic            sclk;
  logic            m_axis_tvalid;
  logic [63:0]     m_axis_tdata;
  logic [15:0]     overrun_count;

  always #5 aclk = ~aclk;

  ad7980_array #(
    .NUM_CH        (NCH),
    .CLK_DIV       (CLK_DIV),
    .CNV_CYCLES    (CNV_CYCLES),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .sdo           (sdo),
    .cnv           (cnv),
    .sclk          (sclk),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overrun_count (overrun_count)
  );

  // Frames as {ch3,ch2,ch1,ch0}: 0-4 cadence, 5-7 back-pressure, 8 stop.
  logic [63:0] fr [9] = '{
    64'h8001_0000_FFFF_1234,
    64'hF0F0_0F0F_5555_AAAA,
    64'hFFFE_7FFF_8000_0001,
    64'h0123_CAFE_BEEF_DEAD,
    64'h1357_CDEF_89AB_4567,
    64'h4444_3333_2222_1111,
    64'h8888_7777_6666_5555,
    64'hCCCC_BBBB_AAAA_9999,
    64'h6978_4B5A_2D3C_0F1E
  };

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int loads = 0;
  int pops = 0;
  int last_rise = 0;
  int nsclk = 0;
  int rises[$];
  logic [63:0] expq[$];
  logic [15:0] adc_val [NCH];
  logic [15:0] adc_sr  [NCH];
  logic a_pc = 1'b0;
  logic a_ps = 1'b0;
  logic m_pc = 1'b0;
  logic m_pv = 1'b0;
  logic m_ps = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // ADC: data loads at CNV fall, next bit appears on SCLK fall.
  always @(negedge aclk) begin
    a_pc <= cnv;
    a_ps <= sclk;
    if (a_pc && !cnv) begin
      for (int k = 0; k < NCH; k++)
        adc_sr[k] <= adc_val[k];
      loads <= loads + 1;
    end else if (a_ps && !sclk) begin
      for (int k = 0; k < NCH; k++)
        adc_sr[k] <= {adc_sr[k][14:0], 1'b0};
    end
  end

  always_comb begin
    sdo = '0;
    for (int k = 0; k < NCH; k++)
      sdo[k] = adc_sr[k][15];
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_pc <= 1'b0;
      m_pv <= 1'b0;
      m_ps <= 1'b0;
    end else begin
      m_pc <= cnv;
      m_pv <= m_axis_tvalid;
      m_ps <= sclk;
      if (cnv && !m_pc) begin
        rises.push_back(cyc);
        last_rise <= cyc;
        nsclk <= 0;
      end else if (sclk && !m_ps) begin
        nsclk <= nsclk + 1;
      end
      if (m_axis_tvalid && !m_pv) begin
        chk("tvalid_latency", 64'(cyc - last_rise),
            64'(LAT));
        chk("sclk_pulses", 64'(nsclk), 64'd16);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", m_axis_tdata, 64'hX);
        end else begin
          chk("tdata", m_axis_tdata, expq.pop_front());
        end
        pops <= pops + 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // which: 0=loads, 1=handshakes, 2=cnv rises
  task automatic wait_for(input int which, input int target,
                          input int budget, input string nm);
    int v;
    v = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk);
      #1;
      v = (which == 0) ? loads :
          (which == 1) ? pops : rises.size();
      if (v >= target) break;
    end
    chk(nm, 64'(v), 64'(target));
  endtask

  task automatic set_adc(input int f);
    for (int k = 0; k < NCH; k++)
      adc_val[k] = fr[f][16*k +: 16];
  endtask

  int base;
  int rb;
  int nr;

  initial begin
    for (int k = 0; k < NCH; k++) adc_val[k] = 16'h0;
    cycles(3);
    aresetn = 1'b1;
    cfg_enable = 1'b1;
    wait_for(2, 1, 100, "first_cnv");
    cycles(80);
    aresetn = 1'b0;
    #1;
    chk("rst_cnv", 64'(cnv), 64'd0);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_overrun", 64'(overrun_count), 64'd0);
    cfg_enable = 1'b0;
    cycles(3);
    aresetn = 1'b1;
    nr = rises.size();
    cycles(50);
    chk("idle_no_cnv", 64'(rises.size()), 64'(nr));
    chk("idle_cnv_low", 64'(cnv), 64'd0);
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);

    base = loads;
    rb = rises.size();
    for (int f = 0; f < 5; f++) begin
      set_adc(f);
      expq.push_back(fr[f] ^ FMT);
      if (f == 0) cfg_enable = 1'b1;
      wait_for(0, base + f + 1, 400, "cadence_load");
    end
    set_adc(5);
    expq.push_back(fr[5] ^ FMT);
    wait_for(1, 5, 400, "cadence_handshakes");
    m_axis_tready = 1'b0;
    chk("cadence_overrun", 64'(overrun_count), 64'd0);
    for (int i = 0; i < 4; i++)
      chk("cnv_period",
          64'(rises[rb+i+1] - rises[rb+i]),
          64'(SAMPLE_PERIOD));

    wait_for(0, base + 6, 400, "bp_load1");
    set_adc(6);
    wait_for(0, base + 7, 400, "bp_load2");
    set_adc(7);
    wait_for(0, base + 8, 400, "bp_load3");
    chk("bp_hold1", m_axis_tdata, fr[5] ^ FMT);
    chk("bp_overrun1", 64'(overrun_count), 64'd1);
    set_adc(8);
    cycles(70);
    chk("bp_hold2", m_axis_tdata, fr[5] ^ FMT);
    chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("bp_overrun2", 64'(overrun_count), 64'd2);
    chk("bp_no_beats", 64'(pops), 64'd5);
    expq.push_back(fr[8] ^ FMT);
    m_axis_tready = 1'b1;
    wait_for(1, 6, 10, "bp_release");

    wait_for(0, base + 9, 400, "stop_load");
    cycles(20);
    cfg_enable = 1'b0;
    wait_for(1, 7, 400, "stop_frame");
    nr = rises.size();
    cycles(1000);
    chk("stop_no_cnv", 64'(rises.size()), 64'(nr));
    chk("stop_cnv_low", 64'(cnv), 64'd0);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    chk("final_overrun", 64'(overrun_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
